// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 signed max pooling over a raster-order feature map.
// Even rows fold column pairs into a line buffer; odd rows combine the
// current pair with the buffered pair and emit one registered result.
module max_pool_2x2 #(
  parameter int IN_W = 5,
  parameter int IN_H = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic signed [15:0] in_data,
  output logic               out_valid,
  output logic signed [15:0] out_data,
  output logic               done
);

  localparam int OUT_W = IN_W / 2;
  localparam int CW    = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW    = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int LB_N  = (OUT_W > 0) ? OUT_W : 1;
  localparam int LBW   = (LB_N > 1) ? $clog2(LB_N) : 1;
  localparam bit W_ODD = (IN_W % 2) != 0;
  localparam bit H_ODD = (IN_H % 2) != 0;
  localparam logic [CW-1:0] COL_LAST = CW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_H - 1);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic signed [15:0] pair_q;
  logic               out_valid_q;
  logic signed [15:0] out_data_q;
  logic signed [15:0] lb_q [LB_N];

  logic               accept;
  logic               col_last;
  logic               row_last;
  logic               in_window;
  logic               pair_we;
  logic               lb_we;
  logic               emit;
  logic [LBW-1:0]     lb_idx;
  logic signed [15:0] lb_rd;
  logic signed [15:0] pair_max;
  logic signed [15:0] win_max;

  // Beat acceptance, raster position update and pooling datapath.
  always_comb begin
    accept   = in_valid && (state_q == RUN) && !clear;
    col_last = (col_q == COL_LAST);
    row_last = (row_q == ROW_LAST);
    // Trailing odd column / odd row samples advance position but never pool.
    in_window = (!W_ODD || !col_last) && (!H_ODD || !row_last);

    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (clear) begin
      col_d   = '0;
      row_d   = '0;
      state_d = RUN;
    end else if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_q + 1'b1;
        if (row_last) begin
          state_d = DONE;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    pair_we  = accept && in_window && !col_q[0];
    lb_we    = accept && in_window && col_q[0] && !row_q[0];
    emit     = accept && in_window && col_q[0] && row_q[0];
    lb_idx   = LBW'(col_q >> 1);
    lb_rd    = lb_q[lb_idx];
    pair_max = (pair_q > in_data) ? pair_q : in_data;
    win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;
  end

  // Control state, position counters, pair register and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= emit;
      if (pair_we) begin
        pair_q <= in_data;
      end
      if (emit) begin
        out_data_q <= win_max;
      end
    end
  end

  // Line buffer of even-row pair maxima; always written before it is read.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_q[lb_idx] <= pair_max;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = (state_q == DONE);

endmodule
